// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG word reader: FSM encoding and counter-width helpers.
package trng_pkg;

  typedef enum logic {
    ST_WARMUP  = 1'b0,
    ST_COLLECT = 1'b1
  } trng_state_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index 0..depth-1 (depth is a power of two >= 2).
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [ptr_w(DEPTH):0]    count
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  // Empty reads return zero so out_data is defined without resetting the storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trng_word_reader.sv
// TRNG read path: warm-up discard, serial-to-word packing, word FIFO with valid/ready.
// Optional repetition-count test enabled by defining TRNG_RCT_EN.
module trng_word_reader
  import trng_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int WARMUP     = 16,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       rct_fail
);

  localparam int WARM_W = cnt_w(WARMUP - 1);
  localparam int BIT_W  = cnt_w(WIDTH - 1);

  trng_state_t      state;
  trng_state_t      state_next;
  logic [WARM_W-1:0] warm_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  // Only WIDTH-1 bits need storing; the WIDTH-th bit completes the word directly.
  logic [WIDTH-2:0]  shifter;
  logic [WIDTH-1:0]  word;
  logic              warm_last;
  logic              bit_last;
  logic              rct_trip;
  logic              push_req;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;

  assign word      = {shifter, bit_in};
  assign warm_last = (warm_cnt == WARM_W'(WARMUP - 1));
  assign bit_last  = (bit_cnt == BIT_W'(WIDTH - 1));
  assign push_req  = (state == ST_COLLECT) & bit_valid & bit_last
                     & ~rct_trip & ~rct_fail & ~flush;
  assign pop_req   = out_ready & ~flush;
  assign out_valid = ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WARMUP;
    else     state <= state_next;
  end

  // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (flush || rct_trip) begin
      state_next = ST_WARMUP;
    end else begin
      case (state)
        ST_WARMUP:  if (bit_valid && warm_last) state_next = ST_COLLECT;
        ST_COLLECT: state_next = ST_COLLECT;
        default:    state_next = ST_WARMUP;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
    end else if (flush || rct_trip) begin
      warm_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
    end else if (bit_valid) begin
      if (state == ST_WARMUP) begin
        warm_cnt <= warm_last ? '0 : warm_cnt + WARM_W'(1);
      end else begin
        shifter <= word[WIDTH-2:0];
        bit_cnt <= bit_last ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  // A completed word is lost only when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                overflow <= 1'b0;
    else if (flush)                                         overflow <= 1'b0;
    else if (push_req && fifo_full && !(pop_req && out_valid)) overflow <= 1'b1;
  end

`ifdef TRNG_RCT_EN
  localparam int RUN_W = cnt_w(RCT_CUTOFF);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             last_bit;

  always_comb begin
    run_next = run_cnt;
    if (bit_valid) begin
      if (run_cnt == '0 || bit_in != last_bit) run_next = RUN_W'(1);
      else if (run_cnt != RUN_W'(RCT_CUTOFF))  run_next = run_cnt + RUN_W'(1);
    end
  end

  // Trips once on reaching the cutoff; the run saturates there afterwards.
  assign rct_trip = bit_valid & ~flush & (run_next == RUN_W'(RCT_CUTOFF))
                    & (run_cnt != RUN_W'(RCT_CUTOFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
      rct_fail <= 1'b0;
    end else if (flush) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
      rct_fail <= 1'b0;
    end else begin
      run_cnt <= run_next;
      if (bit_valid) last_bit <= bit_in;
      if (rct_trip)  rct_fail <= 1'b1;
    end
  end
`else
  assign rct_trip = 1'b0;
  assign rct_fail = 1'b0;
`endif

  trng_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (word),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_trng_word_reader.sv
// Scoreboard bench for trng_word_reader: expected words queued at stimulus, checked at pop.
module tb_trng_word_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       rct_fail;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  trng_word_reader #(
    .WIDTH(8), .DEPTH(4), .WARMUP(16), .RCT_CUTOFF(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .rct_fail   (rct_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a word leaves the FIFO at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no word at %0t", out_data, $time);
      end else begin
        check("pop_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic rdy, input logic fl);
    @(posedge clk); #1;
    bit_valid = v; bit_in = b; out_ready = rdy; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    drive(1'b1, b, rdy, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) send_bit(w[i], rdy);
  endtask

  // Alternating bits starting with 1 and ending with 0, so no long runs accumulate.
  task automatic send_alt(input int n);
    for (int i = 0; i < n; i++) send_bit(~i[0], 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    while (out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("drain_valid", {31'h0, out_valid}, 32'h0);
    check("drain_queue", exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #23;
    check("rst_valid",    {31'h0, out_valid}, 32'h0);
    check("rst_data",     {24'h0, out_data},  32'h0);
    check("rst_count",    {29'h0, fifo_count}, 32'h0);
    check("rst_overflow", {31'h0, overflow},  32'h0);
    check("rst_rct",      {31'h0, rct_fail},  32'h0);
    rst = 1'b0;

    // Basic packing and one-cycle latency.
    send_alt(16);
    idle();
    check("warm_count", {29'h0, fifo_count}, 32'h0);
    send_word(8'hB2, 1'b0);
    exp_q.push_back(8'hB2);
    idle();
    check("lat_valid", {31'h0, out_valid}, 32'h1);
    check("lat_data",  {24'h0, out_data},  32'hB2);
    drain();

    // Overflow: fifth word dropped, first four intact.
    send_word(8'h5A, 1'b0); exp_q.push_back(8'h5A);
    send_word(8'hC3, 1'b0); exp_q.push_back(8'hC3);
    send_word(8'h96, 1'b0); exp_q.push_back(8'h96);
    send_word(8'h3C, 1'b0); exp_q.push_back(8'h3C);
    send_word(8'hA5, 1'b0);
    idle();
    check("ovf_count", {29'h0, fifo_count}, 32'h4);
    check("ovf_flag",  {31'h0, overflow},   32'h1);
    check("ovf_head",  {24'h0, out_data},   32'h5A);
    drain();

    // Full FIFO with simultaneous push and pop.
    do_flush();
    idle();
    check("flush_ovf", {31'h0, overflow}, 32'h0);
    send_alt(16);
    send_word(8'h69, 1'b0); exp_q.push_back(8'h69);
    send_word(8'h4B, 1'b0); exp_q.push_back(8'h4B);
    send_word(8'hD2, 1'b0); exp_q.push_back(8'hD2);
    send_word(8'h2D, 1'b0); exp_q.push_back(8'h2D);
    for (int i = 7; i >= 1; i--) send_bit(8'hE1 >> i, 1'b0);
    exp_q.push_back(8'hE1);
    send_bit(1'b1, 1'b1);
    idle();
    check("pp_count", {29'h0, fifo_count}, 32'h4);
    check("pp_ovf",   {31'h0, overflow},   32'h0);
    check("pp_head",  {24'h0, out_data},   32'h4B);
    drain();

    // Flush mid-word with two words held.
    send_word(8'h33, 1'b0);
    send_word(8'hCC, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    idle();
    check("pre_flush_count", {29'h0, fifo_count}, 32'h2);
    do_flush();
    idle();
    check("fl_count", {29'h0, fifo_count}, 32'h0);
    check("fl_valid", {31'h0, out_valid},  32'h0);
    check("fl_ovf",   {31'h0, overflow},   32'h0);
    check("fl_rct",   {31'h0, rct_fail},   32'h0);
    send_alt(16);
    idle();
    check("fl_warm_count", {29'h0, fifo_count}, 32'h0);
    send_word(8'h9A, 1'b0); exp_q.push_back(8'h9A);
    idle();
    check("fl_word_count", {29'h0, fifo_count}, 32'h1);
    drain();

    // 32 consecutive ones after warm-up.
    do_flush();
    send_alt(16);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
`ifndef TRNG_RCT_EN
    exp_q.push_back(8'hFF);
`endif
    for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b1);
    idle();
`ifdef TRNG_RCT_EN
    check("rct_fail_set", {31'h0, rct_fail}, 32'h1);
    send_alt(24);
    idle();
    check("rct_no_push", {29'h0, fifo_count}, 32'h0);
    check("rct_queue",   exp_q.size(),        32'h0);
    do_flush();
    idle();
    check("rct_fail_clr", {31'h0, rct_fail}, 32'h0);
`else
    check("rct_tied_0", {31'h0, rct_fail}, 32'h0);
    drain();
`endif

    // Asynchronous reset between edges, mid-word.
    do_flush();
    send_alt(16);
    send_word(8'h5A, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    @(posedge clk); #3;
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, out_valid},  32'h0);
    check("arst_data",  {24'h0, out_data},   32'h0);
    check("arst_count", {29'h0, fifo_count}, 32'h0);
    check("arst_ovf",   {31'h0, overflow},   32'h0);
    check("arst_rct",   {31'h0, rct_fail},   32'h0);
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    send_alt(16);
    idle();
    check("arst_warm_count", {29'h0, fifo_count}, 32'h0);
    send_word(8'h3C, 1'b0); exp_q.push_back(8'h3C);
    idle();
    check("arst_word_count", {29'h0, fifo_count}, 32'h1);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
